// File: rtl/song_pkg.sv
// Shared definitions for the song reader: FSM state encoding and default widths.
package song_pkg;

  localparam int DEF_SONG_BITS     = 2;
  localparam int DEF_NOTE_IDX_BITS = 5;
  localparam int DEF_NOTE_BITS     = 6;
  localparam int DEF_DUR_BITS      = 6;
  localparam int ROM_ADDR_BITS     = DEF_SONG_BITS + DEF_NOTE_IDX_BITS;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_WAIT_ROM  = 3'd2;
  localparam logic [2:0] ST_LOAD      = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_ADVANCE   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

endpackage

// File: rtl/song_rom.sv
// Song table with one-cycle synchronous read; the read register only updates when en_i is high.
module song_rom import song_pkg::*; #(
  parameter int ADDR_BITS = ROM_ADDR_BITS,
  parameter int NOTE_BITS = DEF_NOTE_BITS,
  parameter int DUR_BITS  = DEF_DUR_BITS
) (
  input  logic                          clk,
  input  logic                          en_i,
  input  logic [ADDR_BITS-1:0]          addr_i,
  output logic [NOTE_BITS+DUR_BITS-1:0] data_o
);

  logic [NOTE_BITS+DUR_BITS-1:0] data_q;

  // Generated tune table; entry 5 carries a zero duration so the end marker can be exercised.
  function automatic logic [NOTE_BITS+DUR_BITS-1:0] rom_word(input logic [ADDR_BITS-1:0] a);
    int unsigned          ai;
    logic [NOTE_BITS-1:0] n;
    logic [DUR_BITS-1:0]  d;
    ai = 32'(a);
    n  = NOTE_BITS'(ai * 32'd7 + 32'd3);
    d  = (ai == 32'd5) ? '0 : DUR_BITS'(ai % 32'd15 + 32'd1);
    return {n, d};
  endfunction

  always_ff @(posedge clk) begin
    if (en_i) data_q <= rom_word(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/song_reader.sv
// Song reader: steps through a song table, handing notes to the note player on request.
// Optional SONG_END_MARKER_EN: a zero-duration entry ends the song instead of being played.
module song_reader import song_pkg::*; #(
  parameter int SONG_BITS     = DEF_SONG_BITS,
  parameter int NOTE_IDX_BITS = DEF_NOTE_IDX_BITS,
  parameter int NOTE_BITS     = DEF_NOTE_BITS,
  parameter int DUR_BITS      = DEF_DUR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song,
  input  logic                 reset_player,
  input  logic                 note_done,
  output logic [NOTE_BITS-1:0] note,
  output logic [DUR_BITS-1:0]  duration,
  output logic                 new_note,
  output logic                 song_done
);

  localparam int ADDR_W = SONG_BITS + NOTE_IDX_BITS;
  localparam logic [NOTE_IDX_BITS-1:0] IDX_LAST = '1;

  logic [2:0]                    state_q, state_d;
  logic [NOTE_IDX_BITS-1:0]      idx_q, idx_d;
  logic [NOTE_BITS-1:0]          note_q, note_d;
  logic [DUR_BITS-1:0]           dur_q, dur_d;
  logic                          new_note_q, new_note_d;
  logic                          song_done_q, song_done_d;
  logic                          rom_en;
  logic [ADDR_W-1:0]             rom_addr;
  logic [NOTE_BITS+DUR_BITS-1:0] rom_data;
  logic [NOTE_BITS-1:0]          rom_note;
  logic [DUR_BITS-1:0]           rom_dur;
  logic                          end_mark;

  assign rom_en              = (state_q == ST_FETCH);
  assign rom_addr            = {song, idx_q};
  assign {rom_note, rom_dur} = rom_data;

  song_rom #(
    .ADDR_BITS (ADDR_W),
    .NOTE_BITS (NOTE_BITS),
    .DUR_BITS  (DUR_BITS)
  ) u_rom (
    .clk    (clk),
    .en_i   (rom_en),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

`ifdef SONG_END_MARKER_EN
  assign end_mark = (rom_dur == '0);
`else
  assign end_mark = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;
    case (state_q)
      ST_IDLE:     if (play) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_WAIT_ROM;
      // Outputs are loaded on the edge into LOAD so new_note and the note are visible during LOAD.
      ST_WAIT_ROM: begin
        state_d = ST_LOAD;
        if (!end_mark) begin
          note_d     = rom_note;
          dur_d      = rom_dur;
          new_note_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (end_mark) begin
          state_d     = ST_DONE;
          song_done_d = 1'b1;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: if (note_done) state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        if (idx_q == IDX_LAST) begin
          state_d     = ST_DONE;
          song_done_d = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = play ? ST_FETCH : ST_IDLE;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A restart from the mcu overrides every transition and pulse decided above.
    if (reset_player) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      note_d      = note_q;
      dur_d       = dur_q;
      new_note_d  = 1'b0;
      song_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;

endmodule
